// File: rtl/clock_disp_mux.sv
// Scans six snapshotted BCD time digits onto a multiplexed seven-segment display.
// Outputs are registered with one cycle of latency; there is no backpressure.
module clock_disp_mux #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          ACTIVE_LOW_SEG = 1'b1,
  parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec_1,
  input  logic [2:0] sec_2,
  input  logic [3:0] min_1,
  input  logic [2:0] min_2,
  input  logic [3:0] hour_1,
  input  logic [1:0] hour_2,
  input  logic       tick_1hz,
  input  logic       blank_lz,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int unsigned   CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [5:0]    AN_OFF   = ACTIVE_LOW_AN ? 6'h3F : 6'h00;
  localparam logic [6:0]    SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic          DP_OFF   = ACTIVE_LOW_SEG;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] snap_q, snap_d;
  logic            colon_q, colon_d;
  logic            fs_q, fs_d;
  logic [5:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            terminal;
  logic [3:0]      digit;
  logic [5:0]      an_on;
  logic [6:0]      seg_on;
  logic            dp_on;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = 7'h40;
    endcase
  endfunction

  always_comb begin
    terminal = (cnt_q == CNT_LAST);
    cnt_d    = terminal ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    snap_d   = snap_q;
    fs_d     = 1'b0;
    colon_d  = tick_1hz ? ~colon_q : colon_q;

    // The whole frame is latched at once so a digit rollover never tears across slots.
    if (terminal) begin
      if (idx_q == 3'd5) begin
        idx_d  = 3'd0;
        snap_d = {{2'b00, hour_2}, hour_1, {1'b0, min_2}, min_1, {1'b0, sec_2}, sec_1};
        fs_d   = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    case (idx_q)
      3'd0:    digit = snap_q[0];
      3'd1:    digit = snap_q[1];
      3'd2:    digit = snap_q[2];
      3'd3:    digit = snap_q[3];
      3'd4:    digit = snap_q[4];
      default: digit = snap_q[5];
    endcase

    seg_on = bcd_to_seg(digit);
    an_on  = 6'd1 << idx_q;
    dp_on  = colon_q && (idx_q == 3'd2 || idx_q == 3'd4);

    // Leading-zero blanking follows blank_lz live; only the digit value comes from the snapshot.
    if (blank_lz && idx_q == 3'd5 && snap_q[5] == 4'd0) begin
      an_on  = '0;
      seg_on = '0;
    end

    an_d  = an_on ^ AN_OFF;
    seg_d = seg_on ^ SEG_OFF;
    dp_d  = dp_on ^ DP_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      snap_q  <= '0;
      colon_q <= 1'b1;
      fs_q    <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      colon_q <= colon_d;
      fs_q    <= fs_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_clock_disp_mux.sv
// Directed bench for clock_disp_mux with REFRESH_DIV=4 and active-low seg/an.
// k counts posedges since reset release; the output slot seen after posedge k is ((k-1)/4)%6.
module tb_clock_disp_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sec_1;
  logic [2:0] sec_2;
  logic [3:0] min_1;
  logic [2:0] min_2;
  logic [3:0] hour_1;
  logic [1:0] hour_2;
  logic       tick_1hz;
  logic       blank_lz;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int checks = 0;
  int fails  = 0;
  int k      = 0;

  clock_disp_mux #(.REFRESH_DIV(4), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .sec_1(sec_1), .sec_2(sec_2), .min_1(min_1), .min_2(min_2),
    .hour_1(hour_1), .hour_2(hour_2),
    .tick_1hz(tick_1hz), .blank_lz(blank_lz),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int target);
    int guard = 0;
    while (k < target && guard < 1000) begin
      step();
      guard++;
    end
    if (k != target) begin
      fails++;
      $display("FAIL step_to: cycle index %0d, wanted %0d", k, target);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick_1hz = (i == 1);
      step();
      checks++;
      if ({an, seg, dp, frame_start} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL reset_outputs cyc%0d: an=%h seg=%h dp=%b fs=%b, want 3f 7f 1 0",
                 i, an, seg, dp, frame_start);
      end
    end
    tick_1hz = 1'b0;
  endtask

  task automatic test_first_frame();
    int s;
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      s = ((k - 1) / 4) % 6;
      checks++;
      if (seg !== 7'h40 || an !== (6'h3F ^ (6'd1 << s))) begin
        fails++;
        $display("FAIL first_frame k=%0d: an=%h seg=%h, want an=%h seg=40",
                 k, an, seg, 6'h3F ^ (6'd1 << s));
      end
      checks++;
      if (dp !== ((s == 2 || s == 4) ? 1'b0 : 1'b1)) begin
        fails++;
        $display("FAIL first_frame_dp k=%0d: dp=%b", k, dp);
      end
      checks++;
      if (frame_start !== (k == 24)) begin
        fails++;
        $display("FAIL frame_start k=%0d: got %b, want %b", k, frame_start, (k == 24));
      end
    end
  endtask

  task automatic test_second_frame();
    // 12:34:56 -> slots 6,5,4,3,2,1 in active-low form
    logic [6:0] exp_seg [6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    int s;
    for (int i = 0; i < 24; i++) begin
      step();
      s = ((k - 1) / 4) % 6;
      checks++;
      if (seg !== exp_seg[s] || an !== (6'h3F ^ (6'd1 << s))) begin
        fails++;
        $display("FAIL second_frame k=%0d slot%0d: an=%h seg=%h, want an=%h seg=%h",
                 k, s, an, seg, 6'h3F ^ (6'd1 << s), exp_seg[s]);
      end
      checks++;
      if (dp !== ((s == 2 || s == 4) ? 1'b0 : 1'b1)) begin
        fails++;
        $display("FAIL second_frame_dp k=%0d slot%0d: dp=%b", k, s, dp);
      end
      checks++;
      if (frame_start !== (k == 48)) begin
        fails++;
        $display("FAIL second_frame_fs k=%0d: got %b, want %b", k, frame_start, (k == 48));
      end
    end
  endtask

  task automatic test_midframe_change();
    step_to(50);
    checks++;
    if (seg !== 7'h02) begin
      fails++;
      $display("FAIL midframe_before k=%0d: seg=%h, want 02", k, seg);
    end
    sec_1 = 4'd7;
    step_to(52);
    checks++;
    if (seg !== 7'h02) begin
      fails++;
      $display("FAIL midframe_held k=%0d: seg=%h, want 02", k, seg);
    end
    step_to(72);
    checks++;
    if (frame_start !== 1'b1) begin
      fails++;
      $display("FAIL midframe_fs k=%0d: got %b, want 1", k, frame_start);
    end
    step();
    checks++;
    if (an !== 6'h3E || seg !== 7'h78) begin
      fails++;
      $display("FAIL midframe_after k=%0d: an=%h seg=%h, want 3e 78", k, an, seg);
    end
  endtask

  task automatic test_blank();
    hour_2   = 2'd0;
    blank_lz = 1'b1;
    step_to(94);
    checks++;
    if (an !== 6'h1F || seg !== 7'h79) begin
      fails++;
      $display("FAIL blank_old_snapshot k=%0d: an=%h seg=%h, want 1f 79", k, an, seg);
    end
    step_to(118);
    checks++;
    if (an !== 6'h3F || seg !== 7'h7F || dp !== 1'b1) begin
      fails++;
      $display("FAIL blank_on k=%0d: an=%h seg=%h dp=%b, want 3f 7f 1", k, an, seg, dp);
    end
    blank_lz = 1'b0;
    step();
    checks++;
    if (an !== 6'h1F || seg !== 7'h40) begin
      fails++;
      $display("FAIL blank_off k=%0d: an=%h seg=%h, want 1f 40", k, an, seg);
    end
  endtask

  task automatic test_dash_colon();
    sec_1 = 4'hC;
    step_to(122);
    checks++;
    if (an !== 6'h3E || seg !== 7'h3F) begin
      fails++;
      $display("FAIL dash k=%0d: an=%h seg=%h, want 3e 3f", k, an, seg);
    end
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    step_to(130);
    checks++;
    if (dp !== 1'b1 || seg !== 7'h19) begin
      fails++;
      $display("FAIL colon_off_slot2 k=%0d: dp=%b seg=%h, want 1 19", k, dp, seg);
    end
    step_to(138);
    checks++;
    if (dp !== 1'b1 || seg !== 7'h24) begin
      fails++;
      $display("FAIL colon_off_slot4 k=%0d: dp=%b seg=%h, want 1 24", k, dp, seg);
    end
    // second tick lands on the snapshot edge
    step_to(143);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    checks++;
    if (frame_start !== 1'b1) begin
      fails++;
      $display("FAIL tick_snapshot_fs k=%0d: got %b, want 1", k, frame_start);
    end
    step_to(146);
    checks++;
    if (seg !== 7'h3F) begin
      fails++;
      $display("FAIL dash_next_frame k=%0d: seg=%h, want 3f", k, seg);
    end
    step_to(154);
    checks++;
    if (dp !== 1'b0) begin
      fails++;
      $display("FAIL colon_on_again k=%0d: dp=%b, want 0", k, dp);
    end
  endtask

  task automatic test_reset_midframe();
    step_to(158);
    rst = 1'b1;
    step();
    checks++;
    if ({an, seg, dp, frame_start} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL midframe_reset: an=%h seg=%h dp=%b fs=%b, want 3f 7f 1 0",
               an, seg, dp, frame_start);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (an !== 6'h3E || seg !== 7'h40) begin
      fails++;
      $display("FAIL restart_slot0 k=%0d: an=%h seg=%h, want 3e 40", k, an, seg);
    end
    step_to(6);
    checks++;
    if (an !== 6'h3D || seg !== 7'h40 || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL restart_slot1 k=%0d: an=%h seg=%h fs=%b, want 3d 40 0",
               k, an, seg, frame_start);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tick_1hz = 1'b0;
    blank_lz = 1'b0;
    hour_2   = 2'd1;
    hour_1   = 4'd2;
    min_2    = 3'd3;
    min_1    = 4'd4;
    sec_2    = 3'd5;
    sec_1    = 4'd6;

    test_reset();
    test_first_frame();
    test_second_frame();
    test_midframe_change();
    test_blank();
    test_dash_colon();
    test_reset_midframe();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
